im_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction memory and CPU core. It accepts a byte stream (length header plus instruction words), packs the bytes into 32-bit big-endian words and writes them sequentially into the instruction memory write port. It holds the CPU in reset until the image is written, then releases it; a later `load_req` pulse re-enters load mode.

---
 rtl/im_loader_pkg.sv | 16 +
 rtl/im_loader_word_packer.sv | 30 +++
 rtl/im_loader.sv | 121 ++++++++++++
 tb/tb_im_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding and header width.
package im_loader_pkg;

  localparam int HDR_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_LOAD   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/im_loader_word_packer.sv
// 8->32 big-endian packer: three bytes are held in a shift register, and the
// fourth byte completes the word combinationally.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      sr  <= {sr[15:0], in_data};
      cnt <= cnt + 2'd1;
    end
  end

  // The first byte of a word has been shifted to the top by the time the fourth arrives.
  assign word       = {sr, in_data};
  assign word_valid = in_valid && (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Boot loader: consumes a 16-bit length header plus 4N bytes, writes packed
// words into instruction memory and holds the CPU in reset until finished.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_DEPTH = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on every rising edge where rx_valid && rx_ready;
  // rx_ready depends only on state (and rst), never on rx_valid.

  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(IM_DEPTH);
  localparam logic [HDR_W-1:0] ONE_N   = HDR_W'(1);

  state_t           state, state_nx;
  logic [HDR_W-1:0] hdr_n;
  logic [HDR_W-1:0] word_cnt;
  logic             accept;
  logic             pk_clr;
  logic             pk_valid;
  logic [31:0]      pk_word;
  logic             last_word;
  logic [HDR_W-1:0] hdr_full;

  assign rx_ready  = !rst && (state == ST_HDR_HI || state == ST_HDR_LO || state == ST_LOAD);
  assign accept    = rx_valid && rx_ready;
  assign hdr_full  = {hdr_n[HDR_W-1:BYTE_W], rx_data};
  assign last_word = (word_cnt == hdr_n - ONE_N);
  assign dbg_state = state;

  // Any path into a fresh image drops leftover bytes from the packer.
  assign pk_clr = (state == ST_HDR_LO && accept) || (state == ST_DONE && load_req);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .in_valid   (accept && state == ST_LOAD),
    .in_data    (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_HDR_HI: if (accept) state_nx = ST_HDR_LO;
      ST_HDR_LO: if (accept) state_nx = (hdr_full == '0) ? ST_FLUSH : ST_LOAD;
      ST_LOAD:   if (pk_valid && last_word) state_nx = ST_FLUSH;
      ST_FLUSH:  state_nx = ST_DONE;
      ST_DONE:   if (load_req) state_nx = ST_HDR_HI;
      default:   state_nx = ST_HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR_HI;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_n    <= '0;
      word_cnt <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_rst  <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      busy  <= (state_nx != ST_DONE);
      case (state)
        ST_HDR_HI: if (accept) hdr_n[HDR_W-1:BYTE_W] <= rx_data;
        ST_HDR_LO: if (accept) begin
          hdr_n[BYTE_W-1:0] <= rx_data;
          word_cnt          <= '0;
        end
        ST_LOAD: if (pk_valid) begin
          im_wdata <= pk_word;
          im_addr  <= word_cnt[ADDR_W-1:0];
          // Words beyond the memory are still consumed but only flag the error.
          if (word_cnt < DEPTH_N) im_we <= 1'b1;
          else                    err   <= 1'b1;
          if (word_cnt != '1) word_cnt <= word_cnt + ONE_N;
        end
        ST_FLUSH: begin
          cpu_rst <= 1'b0;
          done    <= 1'b1;
        end
        ST_DONE: if (load_req) begin
          cpu_rst  <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          word_cnt <= '0;
          hdr_n    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader (IM_DEPTH=4): scoreboard of expected IM writes fed by the
// image driver, drained by an independent write monitor.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int IM_DEPTH = 4;
  localparam int ADDR_W   = 2;
  localparam int EW       = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              load_req;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   img[$];

  im_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .load_req(load_req), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_im_we",    32'(im_we),     32'd0);
    chk("rst_im_addr",  32'(im_addr),   32'd0);
    chk("rst_im_wdata", im_wdata,       32'd0);
    chk("rst_cpu_rst",  32'(cpu_rst),   32'd1);
    chk("rst_busy",     32'(busy),      32'd1);
    chk("rst_done",     32'(done),      32'd0);
    chk("rst_err",      32'(err),       32'd0);
    chk("rst_rx_ready", 32'(rx_ready),  32'd0);
    chk("rst_state",    32'(dbg_state), 32'(ST_HDR_HI));
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // gap idle cycles precede each byte; load_req is poked randomly in gaps and must be ignored.
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      load_req = ($urandom_range(0, 2) == 0);
      chk("gap_rx_ready", 32'(rx_ready), 32'd1);
    end
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    chk("byte_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic finish_check(input logic exp_err);
    @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
    chk("flush_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("flush_done",    32'(done),    32'd0);
    @(negedge clk);
    chk("end_cpu_rst",  32'(cpu_rst),  32'd0);
    chk("end_done",     32'(done),     32'd1);
    chk("end_busy",     32'(busy),     32'd0);
    chk("end_err",      32'(err),      32'(exp_err));
    chk("end_rx_ready", 32'(rx_ready), 32'd0);
  endtask

  // Reference model: word i of the image lands at address i iff i < IM_DEPTH.
  task automatic do_load(input int n, input int gap);
    logic [15:0] hdr;
    hdr = 16'(n);
    send_byte(hdr[15:8], gap);
    send_byte(hdr[7:0], gap);
    for (int i = 0; i < n; i++) begin
      if (i < IM_DEPTH) exp_q.push_back({ADDR_W'(i), img[i]});
      for (int b = 3; b >= 0; b--) send_byte(img[i][8*b +: 8], gap);
    end
    finish_check(n > IM_DEPTH);
  endtask

  task automatic reload();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("reload_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("reload_done",     32'(done),     32'd0);
    chk("reload_err",      32'(err),      32'd0);
    chk("reload_busy",     32'(busy),     32'd1);
    chk("reload_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (im_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL im_write: got unexpected write addr %0d data %h, required none",
                 im_addr, im_wdata);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          errors++;
          $display("FAIL im_write: got addr %0d data %h, required addr %0d data %h",
                   im_addr, im_wdata, e[EW-1:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    do_reset();

    // Reference image, back-to-back.
    img.delete();
    img.push_back(32'h20080005);
    img.push_back(32'h0000000C);
    do_load(2, 0);

    // Same image with 3 idle cycles between bytes.
    reload();
    do_load(2, 3);

    // Empty image.
    reload();
    do_load(0, 0);

    // Exactly full, then overlong images.
    reload(); rand_img(4); do_load(4, 0);
    reload(); rand_img(6); do_load(6, 1);
    reload(); rand_img(5); do_load(5, 0);

    // Reset mid-word: header 3, word 0, then 2 bytes of word 1.
    reload();
    rand_img(3);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({ADDR_W'(0), img[0]});
    for (int b = 3; b >= 0; b--) send_byte(img[0][8*b +: 8], 0);
    send_byte(img[1][31:24], 0);
    send_byte(img[1][23:16], 0);
    do_reset();
    rand_img(1);
    do_load(1, 0);

    // Randomised images.
    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(0, 7);
      reload();
      rand_img(n);
      do_load(n, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
